// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// jpeg_pkg
// Shared JPEG block constants, coefficient type, zig-zag scan table and
// the per-bank occupancy states used by the zig-zag reorder buffer.
// Revision: 1.0
// ============================================================================
package jpeg_pkg;

    localparam int BLK_N  = 64;
    localparam int COEF_W = 8;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Raster index (8*row+col) of zig-zag scan position 0..63.
    localparam logic [5:0] ZZ [BLK_N] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/zigzag_bank.sv
`default_nettype none
// ============================================================================
// zigzag_bank
// One block of coefficient storage: single write port, single read port
// with a registered read output that holds when no read is issued.
// Revision: 1.0
// ============================================================================
module zigzag_bank
    import jpeg_pkg::*;
#(
    parameter int DW    = COEF_W,
    parameter int DEPTH = BLK_N,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; output is cleared on reset so the buffer output starts at 0.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/zigzag_buf.sv
`default_nettype none
// ============================================================================
// zigzag_buf
// Ping-pong 8x8 block buffer: accepts coefficients in raster order and
// re-emits each block in zig-zag order as one contiguous 64-beat burst.
// Revision: 1.0
// ============================================================================
module zigzag_buf
    import jpeg_pkg::*;
#(
    parameter int DW = COEF_W,
    parameter int N  = BLK_N
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data,
    output logic          data_valid
);

    localparam int          AW   = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_DRAIN = 2'd1,
        RD_GAP   = 2'd2
    } rd_state_t;

    bank_state_t   bank_st [2];
    rd_state_t     rd_state;
    logic          wr_sel;
    logic          rd_sel;
    logic          out_sel;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [DW-1:0] bank_q [2];
    logic          accept;
    logic          drain_done;

    assign in_ready   = (bank_st[wr_sel] != FULL);
    assign accept     = in_valid && in_ready;
    assign drain_done = (rd_state == RD_DRAIN) && (rd_cnt == LAST);

    // The read register of the bank last drained drives the output, so data
    // naturally holds its final beat between bursts.
    assign data = bank_q[out_sel];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        zigzag_bank #(
            .DW    (DW),
            .DEPTH (N)
        ) u_bank (
            .clk   (clk),
            .nrst  (nrst),
            .we    (accept && (wr_sel == 1'(b))),
            .waddr (wr_cnt),
            .wdata (in_data),
            .re    ((rd_state == RD_DRAIN) && (rd_sel == 1'(b))),
            .raddr (ZZ[rd_cnt]),
            .rdata (bank_q[b])
        );
    end

    // Write-side counter, bank select and bank occupancy. Write and free never
    // target the same bank: a write needs a non-FULL bank, a free needs a FULL one.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_sel     <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST) begin
                    bank_st[wr_sel] <= FULL;
                    wr_sel          <= ~wr_sel;
                end else if (bank_st[wr_sel] == EMPTY) begin
                    bank_st[wr_sel] <= FILLING;
                end
            end
            if (drain_done) begin
                bank_st[rd_sel] <= EMPTY;
            end
        end
    end

    // Read-side FSM. GAP is the single idle output cycle between bursts; if the
    // other bank is already full it goes straight on to DRAIN so that
    // back-to-back blocks are separated by exactly one data_valid=0 cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_state   <= RD_IDLE;
            rd_sel     <= 1'b0;
            rd_cnt     <= '0;
            out_sel    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= (rd_state == RD_DRAIN);
            if (rd_state == RD_DRAIN) begin
                out_sel <= rd_sel;
            end
            case (rd_state)
                RD_IDLE: begin
                    rd_cnt <= '0;
                    if (bank_st[rd_sel] == FULL) begin
                        rd_state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST) begin
                        rd_state <= RD_GAP;
                        rd_sel   <= ~rd_sel;
                    end
                end
                RD_GAP: begin
                    rd_cnt <= '0;
                    if (bank_st[rd_sel] == FULL) begin
                        rd_state <= RD_DRAIN;
                    end else begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_buf.sv
`default_nettype none
// ============================================================================
// tb_zigzag_buf
// Scoreboard bench for the zig-zag reorder buffer.
// Revision: 1.0
// ============================================================================
module tb_zigzag_buf;

    localparam int DW = 8;

    logic          clk      = 1'b0;
    logic          nrst     = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic [DW-1:0] data;
    logic          data_valid;

    zigzag_buf #(
        .DW (DW),
        .N  (64)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    int unsigned zz_tab [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [7:0] sb_q [$];
    int n_checks   = 0;
    int n_errs     = 0;
    int cyc        = 0;
    int run        = 0;
    int gap        = 0;
    int bursts     = 0;
    int beats      = 0;
    int first_cyc  = -1;
    int stalls     = 0;
    bit gap_chk    = 1'b0;
    bit seen_burst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every beat and checks framing.
    always @(negedge clk) begin
        if (nrst) begin
            if (data_valid) begin
                if (run == 0) begin
                    if (gap_chk && seen_burst) check_eq("burst_gap", gap, 1);
                    first_cyc = cyc;
                    bursts++;
                end
                run++;
                beats++;
                if (sb_q.size() == 0) check_eq("sb_underflow", sb_q.size(), 1);
                else                  check_eq("beat", data, sb_q.pop_front());
            end else begin
                if (run > 0) begin
                    check_eq("burst_len", run, 64);
                    seen_burst = 1'b1;
                    run = 0;
                    gap = 0;
                end
                gap++;
            end
        end
    end

    // Drives up to max_n samples of a block; called and returns at posedge+1.
    task automatic send_block(input logic [7:0] blk [64], input bit gaps,
                              input int max_n, output int last_cyc);
        int  k      = 0;
        int  budget = 0;
        bit  acc;
        last_cyc = -1;
        while (k < max_n && budget < 4000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = blk[k];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) stalls++;
            @(posedge clk);
            #1;
            budget++;
            if (acc) begin
                k++;
                if (k == 64) begin
                    for (int j = 0; j < 64; j++) sb_q.push_back(blk[zz_tab[j]]);
                    last_cyc = cyc;
                end
            end
        end
        in_valid = 1'b0;
        if (k < max_n) check_eq("send_timeout", k, max_n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && (sb_q.size() != 0 || data_valid || run != 0); i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 0);
    endtask

    task automatic rand_block(output logic [7:0] blk [64]);
        for (int i = 0; i < 64; i++) blk[i] = 8'($urandom_range(0, 255));
    endtask

    logic [7:0] blk_a [64];
    logic [7:0] blk_b [64];
    logic [7:0] blk_c [64];
    int lc;
    int b0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_data_valid", data_valid, 0);
        check_eq("rst_data", data, 0);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single ramp block, latency and framing
        for (int i = 0; i < 64; i++) blk_a[i] = 8'(i);
        bursts = 0;
        send_block(blk_a, 1'b0, 64, lc);
        wait_idle();
        check_eq("latency", first_cyc - lc, 2);
        check_eq("ramp_bursts", bursts, 1);

        // Sparse block with negative coefficients
        for (int i = 0; i < 64; i++) blk_a[i] = 8'h00;
        blk_a[0] = 8'hD8;
        blk_a[2] = 8'hFE;
        blk_a[9] = 8'h01;
        send_block(blk_a, 1'b0, 64, lc);
        wait_idle();

        // Three blocks back-to-back at full rate
        b0 = bursts;
        stalls = 0;
        seen_burst = 1'b0;
        gap_chk = 1'b1;
        rand_block(blk_a);
        rand_block(blk_b);
        rand_block(blk_c);
        send_block(blk_a, 1'b0, 64, lc);
        send_block(blk_b, 1'b0, 64, lc);
        send_block(blk_c, 1'b0, 64, lc);
        wait_idle();
        gap_chk = 1'b0;
        check_eq("b2b_stalls", stalls, 1);
        check_eq("b2b_bursts", bursts - b0, 3);

        // Random input gaps
        b0 = bursts;
        rand_block(blk_a);
        rand_block(blk_b);
        send_block(blk_a, 1'b1, 64, lc);
        send_block(blk_b, 1'b1, 64, lc);
        wait_idle();
        check_eq("gap_bursts", bursts - b0, 2);

        // Reset while one block drains and the next is partially written
        rand_block(blk_a);
        rand_block(blk_b);
        send_block(blk_a, 1'b0, 64, lc);
        send_block(blk_b, 1'b0, 30, lc);
        @(negedge clk);
        check_eq("pre_rst_busy", data_valid, 1);
        #2;
        nrst = 1'b0;
        sb_q.delete();
        run = 0;
        #1;
        check_eq("rst_mid_dv", data_valid, 0);
        check_eq("rst_mid_ready", in_ready, 1);
        check_eq("rst_mid_data", data, 0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        beats = 0;
        b0 = bursts;
        rand_block(blk_c);
        send_block(blk_c, 1'b0, 64, lc);
        wait_idle();
        repeat (80) @(posedge clk);
        #1;
        check_eq("post_rst_beats", beats, 64);
        check_eq("post_rst_bursts", bursts - b0, 1);

        // All-zero block
        for (int i = 0; i < 64; i++) blk_a[i] = 8'h00;
        beats = 0;
        send_block(blk_a, 1'b0, 64, lc);
        wait_idle();
        check_eq("zero_beats", beats, 64);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
